// File: rtl/staging_writeback.sv
// Two-entry skid buffer between the MEM-stage pipeline register and the
// register-file write port; the writeback datum is selected when a bundle is stored.
module staging_writeback #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_wdata,
  output logic [1:0]        count
);

  logic [1:0]        count_q;
  logic              head_rw, tail_rw;
  logic [REG_W-1:0]  head_rd, tail_rd;
  logic [DATA_W-1:0] head_wd, tail_wd;

  logic              push, pop;
  logic              new_rw;
  logic [DATA_W-1:0] new_wd;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Register 0 is hard-wired, so its write enable is dropped at enqueue.
  assign new_rw = in_regwrite && (in_rd != '0);
  assign new_wd = in_memtoreg ? in_mem_data : in_alu_result;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      head_rw <= 1'b0;
      head_rd <= '0;
      head_wd <= '0;
      tail_rw <= 1'b0;
      tail_rd <= '0;
      tail_wd <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
      head_rw <= 1'b0;
      head_rd <= '0;
      head_wd <= '0;
      tail_rw <= 1'b0;
      tail_rd <= '0;
      tail_wd <= '0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_rw <= new_rw;
            head_rd <= in_rd;
            head_wd <= new_wd;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_rw <= new_rw;
            head_rd <= in_rd;
            head_wd <= new_wd;
          end else if (push) begin
            tail_rw <= new_rw;
            tail_rd <= in_rd;
            tail_wd <= new_wd;
            count_q <= 2'd2;
          end else if (pop) begin
            head_rw <= 1'b0;
            head_rd <= '0;
            head_wd <= '0;
            count_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_rw <= tail_rw;
            head_rd <= tail_rd;
            head_wd <= tail_wd;
            tail_rw <= 1'b0;
            tail_rd <= '0;
            tail_wd <= '0;
            count_q <= 2'd1;
          end
        end
        default: count_q <= 2'd0;
      endcase
    end
  end

  assign out_regwrite = out_valid ? head_rw : 1'b0;
  assign out_rd       = out_valid ? head_rd : '0;
  assign out_wdata    = out_valid ? head_wd : '0;

endmodule

// File: tb/tb_staging_writeback.sv
// Scoreboard bench for staging_writeback: directed plan cases followed by
// randomized traffic, checked against a queue-based reference model.
module tb_staging_writeback;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_regwrite = 1'b0;
  logic        in_memtoreg = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_alu_result = '0;
  logic [63:0] in_mem_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_regwrite;
  logic [4:0]  out_rd;
  logic [63:0] out_wdata;
  logic [1:0]  count;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] wd;
  } ent_t;

  ent_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   emitted_64 = 0;

  staging_writeback #(.DATA_W(64), .REG_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
    .in_memtoreg(in_memtoreg), .in_rd(in_rd), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_regwrite(out_regwrite), .out_rd(out_rd), .out_wdata(out_wdata),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented head against the model and pops on consumption.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_regwrite", 64'(out_regwrite), 64'(exp_q[0].rw));
        chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
        chk("out_wdata", out_wdata, exp_q[0].wd);
        if (out_ready && !flush) begin
          if (out_wdata == 64'd64 && exp_q[0].wd == 64'd64) emitted_64 = 1;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_regwrite", 64'(out_regwrite), 64'd0);
        chk("idle_rd", 64'(out_rd), 64'd0);
        chk("idle_wdata", out_wdata, 64'd0);
      end
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic cycle(input bit v, input bit rw, input bit m2r, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] mem,
                       input bit ordy, input bit fl);
    bit   acc;
    ent_t e;
    in_valid = v; in_regwrite = rw; in_memtoreg = m2r; in_rd = rd;
    in_alu_result = alu; in_mem_data = mem; out_ready = ordy; flush = fl;
    acc = v && !fl && (exp_q.size() < 2);
    e.rw = rw && (rd != 0);
    e.rd = rd;
    e.wd = m2r ? mem : alu;
    @(posedge clock);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input bit ordy);
    cycle(0, 0, 0, 5'd0, 64'd0, 64'd0, ordy, 0);
  endtask

  initial begin
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(0);

    // Pass-through, ALU then load data.
    cycle(1, 1, 0, 5'd3, 64'hAAAA, 64'hBBBB, 1, 0);
    idle(1);
    cycle(1, 1, 1, 5'd3, 64'hAAAA, 64'hBBBB, 1, 0);
    idle(1);
    idle(1);

    // Back-pressure: two stored, third refused, then ordered drain.
    cycle(1, 1, 0, 5'd4, 64'hCCCC, 64'h0, 0, 0);
    cycle(1, 1, 0, 5'd5, 64'hDDDD, 64'h0, 0, 0);
    cycle(1, 1, 0, 5'd6, 64'h4, 64'h0, 0, 0);
    idle(1);
    idle(1);
    idle(1);

    // Simultaneous push and pop at count=1.
    cycle(1, 1, 0, 5'd7, 64'd8, 64'd0, 0, 0);
    cycle(1, 1, 0, 5'd7, 64'd16, 64'd0, 1, 0);
    idle(1);
    idle(1);

    // Register-0 suppression.
    cycle(1, 1, 0, 5'd0, 64'd32, 64'd0, 0, 0);
    idle(1);
    idle(1);

    // Flush at full occupancy drops the incoming 64.
    cycle(1, 1, 0, 5'd1, 64'd1, 64'd0, 0, 0);
    cycle(1, 1, 0, 5'd2, 64'd2, 64'd0, 0, 0);
    cycle(1, 1, 0, 5'd9, 64'd64, 64'd0, 0, 1);
    idle(1);
    idle(1);
    chk("flush_no_64", 64'(emitted_64), 64'd0);

    // Asynchronous reset while full.
    cycle(1, 1, 0, 5'd1, 64'h11, 64'd0, 0, 0);
    cycle(1, 1, 0, 5'd2, 64'h22, 64'd0, 0, 0);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_wdata", out_wdata, 64'd0);
    chk("arst_out_regwrite", 64'(out_regwrite), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(1);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [4:0]  rd;
      logic [63:0] a, m;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      a  = {$urandom, $urandom};
      m  = {$urandom, $urandom};
      cycle($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), rd, a, m,
            $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
